bcd_stopwatch: RTL and testbench
================================

# bcd_stopwatch

Decimal event counter/stopwatch that sits directly downstream of the clock divider. It samples the divider's `clkout` square wave as an ordinary data input in the system `clk` domain and turns each rising edge into one count step. It accumulates a DIGITS-wide packed BCD value with start/stop, clear and overflow handling, and presents that value to the seven-segment display stage.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1–8; count width is 4*DIGITS.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `tick_in`  input  1  divided clock from the clock divider; asynchronous to nothing, but slower than `clk`/4 and treated as a level.
- `start_stop`  input  1  level from a debounced button; each rising edge toggles run state.
- `clear`  input  1  level; while high, the count is held at zero.
- `lap`  input  1  level; each rising edge toggles display freeze (only with the lap feature, see Configuration).
- `bcd`  output  4*DIGITS  displayed count, packed BCD; least-significant digit is in bits [3:0].
- `running`  output  1  high in the RUN state.
- `overflow`  output  1  sticky; set on wrap from all-nines to zero.

## Operation
- Input conditioning:
  - `tick_in` passes through a 2-flop synchronizer (s1, s2) plus a history flop (s3).
  - `tick_pulse = s2 & ~s3`, one `clk` cycle long per rising edge of `tick_in`.
  - `start_stop` and `lap` each use a 1-flop history to form a rising-edge pulse. No synchronizer is applied; these inputs are already in the `clk` domain.
- Run control has two states, STOPPED and RUNNING:
  - STOPPED --start_stop pulse--> RUNNING.
  - RUNNING --start_stop pulse--> STOPPED.
  - `running` = (state == RUNNING).
- Count:
  - On a `tick_pulse` while RUNNING, the internal count increments by 1 in BCD.
  - Digit i carries into digit i+1 when digit i goes from 9 to 0. No digit ever holds a value of 10–15.
  - When all digits are 9, the count wraps to zero and sets `overflow`.
- Clear:
  - While `clear` is high, the count is forced to zero, `overflow` is cleared and any lap freeze is released.
  - Run state is unchanged by `clear`.
- Display: `bcd` equals the internal count unless a lap freeze is active.
- Simultaneous events in one cycle:
  - `clear` and `tick_pulse`: clear wins, count = 0.
  - `start_stop` pulse and `tick_pulse`: the tick is evaluated against the state before the toggle. STOPPED→RUN does not count that tick; RUN→STOPPED does count it.
  - Wrap and `clear`: clear wins, `overflow` = 0.
- Reset, including mid-count: count = 0, `bcd` = 0, `overflow` = 0, `running` = 0, state = STOPPED, lap freeze off. All synchronizer and history flops are cleared to 0.
  - Consequence: if `tick_in` is high when `rst` is released, that level produces one `tick_pulse`. It is counted only if RUNNING, which cannot happen in the first cycles after reset.

## Timing
- Every output is registered. Reset values: `bcd` = 0, `running` = 0, `overflow` = 0.
- Tick latency: if `tick_in` is first sampled high at clk edge k, the count (and `bcd` when not frozen) updates at edge k+2.
- `start_stop` latency: if sampled high at edge k after being low, `running` changes at edge k+1.
- `clear` latency: if sampled high at edge k, `bcd` = 0 and `overflow` = 0 after edge k+1.
- `overflow` rises on the same edge at which the count wraps to zero.
- `tick_in` high and low phases must each be at least 2 `clk` periods. A shorter `tick_in` pulse may be missed; this is legal, not an error.

## Configuration
- Macro: `BCD_STOPWATCH_LAP_EN`.
- Defined:
  - In RUNNING, a `lap` rising edge captures the internal count into a lap register. `bcd` then shows the lap register while counting continues underneath.
  - A second `lap` rising edge, or `clear`, releases the freeze; `bcd` tracks the count from the next edge.
  - `lap` edges while STOPPED are ignored.
  - A freeze persists across RUN→STOPPED.
- Undefined:
  - The `lap` port exists but is ignored.
  - No lap register is synthesized.
  - `bcd` always equals the internal count.

## Test plan
- Reset then start: assert `rst` for 2 cycles, pulse `start_stop`, apply 12 `tick_in` periods of 8 `clk` each → `bcd` = 0x0012, `running` = 1, `overflow` = 0.
- Carry and wrap (DIGITS = 4): preload by ticking to 0x9998, then 2 ticks → `bcd` reads 0x9999, then 0x0000 with `overflow` = 1. Assert `clear` → `overflow` = 0.
- Stopped ignores ticks: from `bcd` = 0x0005, pulse `start_stop` (→ STOPPED), apply 3 ticks → `bcd` stays 0x0005 and `running` = 0.
- Simultaneous events: align `clear` with a `tick_pulse` → `bcd` = 0x0000. Align a STOPPED→RUN `start_stop` pulse with a `tick_pulse` → count unchanged.
- Mid-count reset: at `bcd` = 0x0347 while RUNNING, assert `rst` for 1 cycle → `bcd` = 0, `running` = 0. Following ticks do not count until `start_stop` is pulsed.
- Lap (with `BCD_STOPWATCH_LAP_EN` defined): at count 0x0020, pulse `lap`, then apply 5 ticks → `bcd` holds 0x0020. Pulse `lap` again → `bcd` = 0x0025. Without the macro, the same stimulus gives `bcd` = 0x0025 throughout.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// Packed-BCD stopwatch counting rising edges of a divided clock, with start/stop, clear and sticky overflow.
// Define BCD_STOPWATCH_LAP_EN to build the lap (display freeze) register; otherwise the lap input is ignored.

module bcd_digit (
    input  logic [3:0] d,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);
    always_comb begin
        cout = cin && (d == 4'd9);
        if (!cin)
            q = d;
        else if (d == 4'd9)
            q = 4'd0;
        else
            q = d + 4'd1;
    end
endmodule

module bcd_stopwatch #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_in,
    input  logic                start_stop,
    input  logic                clear,
    input  logic                lap,
    output logic [4*DIGITS-1:0] bcd,
    output logic                running,
    output logic                overflow
);
    typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

    state_t                 state;
    logic                   s1, s2, s3;
    logic                   tick_pulse;
    logic                   ss_q, ss_p, clr_q;
    logic [DIGITS-1:0][3:0] cnt, cnt_inc, cnt_nxt;
    logic [DIGITS:0]        carry;

    assign tick_pulse = s2 & ~s3;
    // Tick is qualified with the pre-toggle state, so a stop pulse still counts a coincident tick.
    assign carry[0]   = tick_pulse && (state == RUNNING);
    assign cnt_nxt    = clr_q ? '0 : cnt_inc;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit u_dig (
            .d    (cnt[i]),
            .cin  (carry[i]),
            .q    (cnt_inc[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            ss_q     <= 1'b0;
            ss_p     <= 1'b0;
            clr_q    <= 1'b0;
            state    <= STOPPED;
            running  <= 1'b0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            s1    <= tick_in;
            s2    <= s1;
            s3    <= s2;
            ss_q  <= start_stop;
            ss_p  <= start_stop & ~ss_q;
            clr_q <= clear;
            if (ss_p) begin
                case (state)
                    STOPPED: begin state <= RUNNING; running <= 1'b1; end
                    default: begin state <= STOPPED; running <= 1'b0; end
                endcase
            end
            cnt <= cnt_nxt;
            if (clr_q)
                overflow <= 1'b0;
            else if (carry[DIGITS])
                overflow <= 1'b1;
        end
    end

`ifdef BCD_STOPWATCH_LAP_EN
    logic                   lap_q, lap_p, frz, frz_nxt;
    logic [DIGITS-1:0][3:0] lap_r, lap_nxt, bcd_r;

    always_comb begin
        frz_nxt = frz;
        if (clr_q)
            frz_nxt = 1'b0;
        else if (lap_p && running)
            frz_nxt = ~frz;
        // Freeze entry captures the count as it stands before this edge's update.
        lap_nxt = frz ? lap_r : cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q <= 1'b0;
            lap_p <= 1'b0;
            frz   <= 1'b0;
            lap_r <= '0;
            bcd_r <= '0;
        end else begin
            lap_q <= lap;
            lap_p <= lap & ~lap_q;
            frz   <= frz_nxt;
            lap_r <= lap_nxt;
            bcd_r <= frz_nxt ? lap_nxt : cnt_nxt;
        end
    end

    assign bcd = bcd_r;
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign bcd        = cnt;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch: directed plan plus random ops against an integer reference model.

module tb_bcd_stopwatch;
    localparam int D    = 4;
    localparam int MAXV = 9999;
`ifdef BCD_STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst, tick_in, start_stop, clear, lap;
    logic [4*D-1:0] bcd;
    logic           running, overflow;

    always #5 clk = ~clk;

    bcd_stopwatch #(.DIGITS(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .bcd        (bcd),
        .running    (running),
        .overflow   (overflow)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        run;
        logic        ovf;
    } exp_t;

    exp_t  eq[$];
    string nq[$];
    int    errors = 0;
    int    checks = 0;
    logic  chk_req = 1'b0;

    int m_cnt = 0, m_lap = 0;
    bit m_run = 0, m_ovf = 0, m_frz = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic m_tick();
        if (m_run) begin
            if (m_cnt == MAXV) begin
                m_cnt = 0;
                m_ovf = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic m_clear();
        m_cnt = 0;
        m_ovf = 0;
        m_frz = 0;
    endtask

    task automatic m_lapop();
        if (LAP && m_run) begin
            if (!m_frz) m_lap = m_cnt;
            m_frz = !m_frz;
        end
    endtask

    task automatic m_reset();
        m_cnt = 0; m_run = 0; m_ovf = 0; m_frz = 0; m_lap = 0;
    endtask

    // The monitor samples the DUT just after the posedge following this call.
    task automatic check(input string nm);
        exp_t e;
        e.bcd = to_bcd(m_frz ? m_lap : m_cnt);
        e.run = m_run;
        e.ovf = m_ovf;
        eq.push_back(e);
        nq.push_back(nm);
        chk_req = 1'b1;
        @(negedge clk);
        chk_req = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t  e;
        string nm;
        if (chk_req) begin
            #1;
            checks++;
            if (eq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: sample with empty queue, bcd=%h", bcd);
            end else begin
                e  = eq.pop_front();
                nm = nq.pop_front();
                if (bcd !== e.bcd || running !== e.run || overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL %s: got bcd=%h running=%b overflow=%b, expected bcd=%h running=%b overflow=%b",
                             nm, bcd, running, overflow, e.bcd, e.run, e.ovf);
                end
            end
        end
    end

    task automatic do_tick(input int per);
        tick_in = 1'b1;
        repeat (per / 2) @(negedge clk);
        tick_in = 1'b0;
        repeat (per / 2) @(negedge clk);
        m_tick();
    endtask

    task automatic do_ss();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        repeat (2) @(negedge clk);
        m_run = !m_run;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
        m_clear();
    endtask

    task automatic do_lap();
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        repeat (2) @(negedge clk);
        m_lapop();
    endtask

    // kind 0: clear coincides with the tick; kind 1: start_stop pulse coincides with the tick.
    task automatic do_aligned(input int kind);
        tick_in = 1'b1;
        @(negedge clk);
        if (kind == 0) clear = 1'b1;
        else           start_stop = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        start_stop = 1'b0;
        @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        if (kind == 0) begin
            m_clear();
        end else begin
            m_tick();
            m_run = !m_run;
        end
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int r;
        rst = 1'b1; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_state");

        // start_stop latency: running changes one edge after the level is sampled
        start_stop = 1'b1;
        check("ss_edge_k");
        start_stop = 1'b0;
        m_run = 1;
        check("ss_edge_k1");
        @(negedge clk);

        // tick latency: count moves two edges after tick_in is first sampled
        tick_in = 1'b1;
        check("tick_edge_k");
        check("tick_edge_k1");
        m_tick();
        check("tick_edge_k2");
        @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        repeat (11) do_tick(8);
        check("twelve_ticks");

        do_clear();
        check("clear_zero");
        repeat (5) do_tick(4);
        check("five_ticks");
        do_ss();
        repeat (3) do_tick(4);
        check("stopped_ignores");

        do_aligned(1);
        check("ss_start_with_tick");
        do_aligned(1);
        check("ss_stop_with_tick");
        do_ss();
        do_aligned(0);
        check("clear_with_tick");

        repeat (9998) do_tick(4);
        check("preload_9998");
        do_tick(4);
        check("all_nines");
        do_tick(4);
        check("wrap_overflow");
        clear = 1'b1;
        check("clear_edge_k");
        clear = 1'b0;
        m_clear();
        check("clear_edge_k1");

        repeat (347) do_tick(4);
        check("at_0347");
        tick_in = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset");
        repeat (2) do_tick(4);
        check("post_reset_stopped");
        do_ss();
        do_tick(4);
        check("post_reset_run");

        do_clear();
        repeat (20) do_tick(4);
        check("lap_at_20");
        do_lap();
        repeat (5) do_tick(4);
        check("lap_hold");
        do_lap();
        check("lap_release");

        repeat (300) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5)      do_tick((r[0]) ? 6 : 4);
            else if (r == 6) do_ss();
            else if (r == 7) do_clear();
            else if (r == 8) do_lap();
            else             do_aligned(int'($urandom_range(0, 1)));
            check("random_op");
        end

        repeat (3) @(negedge clk);
        if (eq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", eq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
